// File: rtl/noc_pkg.sv
// Shared NoC definitions: injection FSM states and the default flit width.
package noc_pkg;

  localparam int NOC_FLIT_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } noc_state_e;

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// Requester-side and router-side handshake of the injection arbiter.
interface noc_inject_arbiter_if
  import noc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = NOC_FLIT_W
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*FLIT_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        req_is_header;
  logic [NUM_REQ-1:0]        req_is_tail;

  logic                      out_valid;
  logic                      out_ready;
  logic [FLIT_W-1:0]         out_flit;
  logic                      out_is_header;
  logic                      out_is_tail;

  // master: traffic sources plus the router receive port
  modport master (
    output req_valid, req_flit, req_is_header, req_is_tail, out_ready,
    input  req_ready, out_valid, out_flit, out_is_header, out_is_tail
  );

  modport slave (
    input  req_valid, req_flit, req_is_header, req_is_tail, out_ready,
    output req_ready, out_valid, out_flit, out_is_header, out_is_tail
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of req at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  int j;

  // Scan from the farthest position back to ptr so the closest hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    j       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Node injection scheduler: round-robin at packet boundaries, wormhole lock
// until tail, one registered output slot toward the router receive port.
module noc_inject_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = NOC_FLIT_W,
  parameter int CNT_W   = 16
) (
  input  logic                 noc_clk,
  input  logic                 noc_rst_n,
  noc_inject_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic                 err_no_header,
  output logic                 err_hdr_mid
);

  localparam int                IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  noc_state_e         state_q;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   lock_idx_q;
  logic               out_valid_q, out_hdr_q, out_tail_q;
  logic [FLIT_W-1:0]  out_flit_q;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic               err_nh_q, err_hm_q;

  logic               slot_free, accept;
  logic [NUM_REQ-1:0] rr_gnt, ready;
  logic [IDX_W-1:0]   rr_idx, sel_idx;
  logic [FLIT_W-1:0]  sel_flit;
  logic               sel_hdr, sel_tail;

  assign slot_free = !out_valid_q || bus.out_ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (bus.req_valid & bus.req_is_header),
    .ptr     (rr_ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Ready is gated by reset so nothing looks accepted while held in reset.
  always_comb begin
    ready   = '0;
    sel_idx = rr_idx;
    if (state_q == IDLE) begin
      ready = rr_gnt & {NUM_REQ{slot_free}};
    end else begin
      ready[lock_idx_q] = slot_free;
      sel_idx           = lock_idx_q;
    end
    if (!noc_rst_n) ready = '0;
  end

  assign bus.req_ready = ready;
  assign accept        = |(bus.req_valid & ready);
  assign sel_flit      = bus.req_flit[sel_idx*FLIT_W +: FLIT_W];
  assign sel_hdr       = bus.req_is_header[sel_idx];
  assign sel_tail      = bus.req_is_tail[sel_idx];
  assign rr_ptr_d      = (rr_idx == LAST_IDX) ? '0 : rr_idx + 1'b1;
  assign pkt_cnt_d     = pkt_cnt_q + 1'b1;

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_hdr_q   <= 1'b0;
      out_tail_q  <= 1'b0;
      pkt_cnt_q   <= '0;
      err_nh_q    <= 1'b0;
      err_hm_q    <= 1'b0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_flit_q  <= sel_flit;
        out_hdr_q   <= sel_hdr;
        out_tail_q  <= sel_tail;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (out_valid_q && bus.out_ready && out_tail_q) pkt_cnt_q <= pkt_cnt_d;

      case (state_q)
        IDLE: begin
          if (|(bus.req_valid & ~bus.req_is_header)) err_nh_q <= 1'b1;
          if (accept) begin
            rr_ptr_q <= rr_ptr_d;
            if (!sel_tail) begin
              state_q    <= LOCKED;
              lock_idx_q <= sel_idx;
            end
          end
        end
        LOCKED: begin
          // A stray header mid-packet is flagged but still forwarded.
          if (accept) begin
            if (sel_hdr)  err_hm_q <= 1'b1;
            if (sel_tail) state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_flit      = out_flit_q;
  assign bus.out_is_header = out_hdr_q;
  assign bus.out_is_tail   = out_tail_q;
  assign pkt_cnt           = pkt_cnt_q;
  assign err_no_header     = err_nh_q;
  assign err_hdr_mid       = err_hm_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Bench for noc_inject_arbiter: packet generators per requester and a
// cycle-level reference of the scheduling rules, plus directed scenario checks.
module tb_noc_inject_arbiter;
  import noc_pkg::*;

  localparam int N  = 4;
  localparam int FW = 32;
  localparam int CW = 4;

  logic          noc_clk   = 1'b0;
  logic          noc_rst_n = 1'b0;
  logic [CW-1:0] pkt_cnt;
  logic          err_no_header, err_hdr_mid;

  noc_inject_arbiter_if #(.NUM_REQ(N), .FLIT_W(FW)) bus ();

  noc_inject_arbiter #(.NUM_REQ(N), .FLIT_W(FW), .CNT_W(CW)) dut (
    .noc_clk       (noc_clk),
    .noc_rst_n     (noc_rst_n),
    .bus           (bus),
    .pkt_cnt       (pkt_cnt),
    .err_no_header (err_no_header),
    .err_hdr_mid   (err_hdr_mid)
  );

  always #5 noc_clk = ~noc_clk;

  int total = 0;
  int bad   = 0;

  // reference state
  bit          m_lock, m_ov, m_hdr, m_tail, m_enh, m_ehm;
  int          m_own, m_ptr, m_cnt;
  logic [FW-1:0] m_flit;

  // generators
  int g_pkts[N], g_len[N], g_pos[N], g_lmin[N], g_lmax[N], g_vpct[N], g_seq[N];
  bit bad_nohdr[N], bad_midhdr[N];
  int rdy_pct;

  int            grants[$];
  logic [FW-1:0] outq[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic newpkt(int i);
    g_pos[i] = 0;
    g_len[i] = $urandom_range(g_lmin[i], g_lmax[i]);
  endtask

  task automatic cfg(int i, int pkts, int lmin, int lmax, int vpct);
    g_pkts[i] = pkts; g_lmin[i] = lmin; g_lmax[i] = lmax; g_vpct[i] = vpct;
    newpkt(i);
  endtask

  task automatic mreset();
    m_lock = 0; m_own = 0; m_ptr = 0; m_ov = 0; m_hdr = 0; m_tail = 0;
    m_flit = '0; m_cnt = 0; m_enh = 0; m_ehm = 0;
    for (int i = 0; i < N; i++) begin
      g_pkts[i] = 0; bad_nohdr[i] = 0; bad_midhdr[i] = 0;
    end
    grants.delete(); outq.delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bit v, h, t;
      v = (g_pkts[i] > 0) && (g_pos[i] == 0 || $urandom_range(0, 99) < g_vpct[i]);
      h = (g_pos[i] == 0);
      t = (g_pos[i] == g_len[i] - 1);
      if (bad_midhdr[i] && g_pos[i] > 0) h = 1;
      if (bad_nohdr[i]) begin v = 1; h = 0; t = 1; end
      bus.req_valid[i]            = v;
      bus.req_is_header[i]        = h;
      bus.req_is_tail[i]          = t;
      bus.req_flit[i*FW +: FW]    = {8'(i), 24'(g_seq[i])};
    end
    bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  // Check outputs at the falling edge, then advance the reference to the next rising edge.
  task automatic step();
    logic [N-1:0]  er, vld;
    logic [FW-1:0] f;
    bit slot, h, t;
    int w, j;
    @(negedge noc_clk);
    vld  = bus.req_valid;
    slot = !m_ov || bus.out_ready;
    w    = -1;
    er   = '0;
    if (m_lock) w = m_own;
    else for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (w < 0 && vld[j] && bus.req_is_header[j]) w = j;
    end
    if (w >= 0 && slot) er[w] = 1'b1;

    chk("req_ready",     bus.req_ready,     er);
    chk("out_valid",     bus.out_valid,     m_ov);
    chk("out_flit",      bus.out_flit,      m_flit);
    chk("out_is_header", bus.out_is_header, m_hdr);
    chk("out_is_tail",   bus.out_is_tail,   m_tail);
    chk("pkt_cnt",       pkt_cnt,           m_cnt % 16);
    chk("err_no_header", err_no_header,     m_enh);
    chk("err_hdr_mid",   err_hdr_mid,       m_ehm);

    if (m_ov && bus.out_ready) begin
      if (m_tail) m_cnt++;
      outq.push_back(m_flit);
    end
    if (!m_lock && |(vld & ~bus.req_is_header)) m_enh = 1;
    if (w >= 0 && er[w] && vld[w]) begin
      f = bus.req_flit[w*FW +: FW];
      h = bus.req_is_header[w];
      t = bus.req_is_tail[w];
      m_ov = 1; m_flit = f; m_hdr = h; m_tail = t;
      grants.push_back(w);
      if (!m_lock) begin
        m_ptr = (w + 1) % N;
        if (!t) begin m_lock = 1; m_own = w; end
      end else begin
        if (h) m_ehm = 1;
        if (t) m_lock = 0;
      end
      g_seq[w]++;
      if (g_pos[w] > 0) bad_midhdr[w] = 0;
      if (t) begin g_pkts[w]--; newpkt(w); end
      else g_pos[w]++;
    end else if (bus.out_ready) begin
      m_ov = 0;
    end
    @(posedge noc_clk); #1;
  endtask

  function automatic bit pending();
    bit p;
    p = m_ov;
    for (int i = 0; i < N; i++) if (g_pkts[i] > 0) p = 1;
    return p;
  endfunction

  task automatic drain(int maxc, string tag);
    int c;
    bit busy;
    c = 0;
    do begin
      drive(); step(); c++;
      busy = pending();
    end while (busy && c < maxc);
    chk({tag, "_drain"}, busy, 0);
  endtask

  task automatic reset_outputs_check(string tag);
    chk({tag, "_ready"},  bus.req_ready,     0);
    chk({tag, "_valid"},  bus.out_valid,     0);
    chk({tag, "_flit"},   bus.out_flit,      0);
    chk({tag, "_hdr"},    bus.out_is_header, 0);
    chk({tag, "_tail"},   bus.out_is_tail,   0);
    chk({tag, "_cnt"},    pkt_cnt,           0);
    chk({tag, "_enh"},    err_no_header,     0);
    chk({tag, "_ehm"},    err_hdr_mid,       0);
  endtask

  initial begin
    int s1, s2, base, n0, n3, viol, n2;
    int last[N];
    for (int i = 0; i < N; i++) begin g_seq[i] = 0; g_len[i] = 1; g_pos[i] = 0; end
    mreset();
    rdy_pct = 100;

    // reset values, with every requester already holding a header
    for (int i = 0; i < N; i++) cfg(i, 1, 1, 1, 100);
    drive();
    #2;
    reset_outputs_check("rst");
    @(posedge noc_clk); #1 noc_rst_n = 1'b1;

    // single-flit packets from all four requesters
    drain(40, "p1");
    chk("p1_ngrant", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++) chk("p1_order", grants[k], k);
    chk("p1_pktcnt", pkt_cnt, 4);

    // wormhole lock: req1 3-flit packet with gaps, req2 header waiting
    grants.delete(); outq.delete();
    s1 = g_seq[1]; s2 = g_seq[2];
    cfg(1, 1, 3, 3, 40);
    cfg(2, 1, 1, 1, 100);
    drain(200, "p2");
    chk("p2_nout", outq.size(), 4);
    if (outq.size() == 4) begin
      for (int k = 0; k < 3; k++) chk("p2_a", outq[k], {8'd1, 24'(s1 + k)});
      chk("p2_b", outq[3], {8'd2, 24'(s2)});
    end

    // backpressure: five stalled cycles mid-packet
    outq.delete();
    base = g_seq[0];
    cfg(0, 1, 4, 4, 100);
    drive(); step(); drive(); step();
    rdy_pct = 0;
    for (int k = 0; k < 5; k++) begin
      drive(); step();
      chk("bp_hold", bus.out_flit, {8'd0, 24'(base + 1)});
      chk("bp_ready", bus.req_ready, 0);
    end
    rdy_pct = 100;
    drain(40, "p3");
    chk("bp_nout", outq.size(), 4);
    if (outq.size() == 4)
      for (int k = 0; k < 4; k++) chk("bp_seq", outq[k], {8'd0, 24'(base + k)});

    // fairness: req0 and req3 each stream 2-flit packets
    grants.delete(); outq.delete();
    cfg(0, 50, 2, 2, 100);
    cfg(3, 50, 2, 2, 100);
    drain(400, "p4");
    n0 = 0; n3 = 0; viol = 0;
    foreach (grants[k]) begin
      if (grants[k] == 0) n0++;
      if (grants[k] == 3) n3++;
    end
    for (int k = 0; k + 2 < grants.size(); k += 2) if (grants[k] == grants[k+2]) viol++;
    chk("fair_ngrant", grants.size(), 200);
    chk("fair_req0", n0 / 2, 50);
    chk("fair_req3", n3 / 2, 50);
    chk("fair_alt", viol, 0);

    // random traffic with random backpressure
    grants.delete(); outq.delete();
    for (int i = 0; i < N; i++) cfg(i, 15, 1, 4, 70);
    rdy_pct = 70;
    drain(3000, "p5");
    rdy_pct = 100;
    for (int i = 0; i < N; i++) last[i] = -1;
    viol = 0;
    foreach (outq[k]) begin
      int r, s;
      r = int'(outq[k][31:24]);
      s = int'(outq[k][23:0]);
      if (r < N) begin
        if (last[r] >= 0 && s != last[r] + 1) viol++;
        last[r] = s;
      end else viol++;
    end
    chk("rnd_order", viol, 0);
    chk("rnd_nout", outq.size(), grants.size());

    // non-header flit while idle
    grants.delete(); outq.delete();
    bad_nohdr[2] = 1;
    for (int k = 0; k < 4; k++) begin drive(); step(); end
    chk("enh_set", err_no_header, 1);
    n2 = 0;
    foreach (grants[k]) if (grants[k] == 2) n2++;
    chk("enh_nogrant", n2, 0);
    bad_nohdr[2] = 0;

    // header presented mid-packet by the locked requester
    outq.delete();
    cfg(1, 1, 3, 3, 100);
    bad_midhdr[1] = 1;
    drain(40, "p6");
    chk("ehm_set", err_hdr_mid, 1);
    chk("ehm_fwd", outq.size(), 3);

    // asynchronous reset while locked
    cfg(0, 1, 4, 4, 100);
    drive(); step(); drive(); step();
    noc_rst_n = 1'b0;
    #1;
    reset_outputs_check("arst");
    mreset();
    drive();
    @(posedge noc_clk); #1 noc_rst_n = 1'b1;

    // counter wrap on a 4-bit counter
    cfg(0, 9, 1, 1, 100);
    cfg(1, 8, 1, 1, 100);
    drain(100, "p7");
    chk("wrap", pkt_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
